// File: rtl/demux_nch_fifo_if.sv
// Bundle of the demux data/handshake signals between the producer/consumer side and the demux.
// Optional err_cnt signal exists only when DEMUX_ERR_CNT_EN is defined.
interface demux_nch_fifo_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int DEPTH  = 4
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]    data_in;
    logic                 valid_in;
    logic [SEL_W-1:0]     sel;
    logic                 ready_in;
    logic [CH*DATA_W-1:0] data_out;
    logic [CH-1:0]        valid_out;
    logic [CH-1:0]        pop;
    logic [CH*LVL_W-1:0]  level;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0]           err_cnt;
`endif

`ifdef DEMUX_ERR_CNT_EN
    modport master (
        output data_in, valid_in, sel, pop,
        input  ready_in, data_out, valid_out, level, err_cnt
    );
    modport slave (
        input  data_in, valid_in, sel, pop,
        output ready_in, data_out, valid_out, level, err_cnt
    );
`else
    modport master (
        output data_in, valid_in, sel, pop,
        input  ready_in, data_out, valid_out, level
    );
    modport slave (
        input  data_in, valid_in, sel, pop,
        output ready_in, data_out, valid_out, level
    );
`endif
endinterface

// File: rtl/demux_nch_fifo.sv
// 1-to-CH demultiplexer with a DEPTH-entry first-word-fall-through FIFO per output channel.
// Define DEMUX_ERR_CNT_EN to add a saturating 8-bit dropped-word counter (err_cnt).
module demux_nch_fifo #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    demux_nch_fifo_if.slave bus
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CH-1:0][PTR_W-1:0] wptr_q, wptr_d;
    logic [CH-1:0][PTR_W-1:0] rptr_q, rptr_d;
    logic [CH-1:0][LVL_W-1:0] level_q, level_d;
    logic [DATA_W-1:0]        mem_q [CH][DEPTH];
    logic [DATA_W-1:0]        mem_d [CH][DEPTH];

    logic [CH-1:0] push;
    logic [CH-1:0] pop_ok;
    logic          sel_hit;
    logic          sel_full;
    logic          ready;

    // Decode sel by comparison so an out-of-range index never addresses the arrays.
    always_comb begin
        sel_hit  = 1'b0;
        sel_full = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                sel_full = (level_q[i] == LVL_W'(DEPTH));
            end
        end
        ready        = sel_hit && !sel_full;
        bus.ready_in = ready;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        mem_d   = mem_q;
        push    = '0;
        pop_ok  = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            push[i]   = bus.valid_in && ready && (bus.sel == SEL_W'(i));
            pop_ok[i] = bus.pop[i] && (level_q[i] != '0);
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = bus.data_in;
                wptr_d[i]           = wptr_q[i] + 1'b1;
            end
            if (pop_ok[i]) begin
                rptr_d[i] = rptr_q[i] + 1'b1;
            end
            case ({push[i], pop_ok[i]})
                2'b10:   level_d[i] = level_q[i] + 1'b1;
                2'b01:   level_d[i] = level_q[i] - 1'b1;
                default: level_d[i] = level_q[i];
            endcase
        end
    end

    // Head word is masked while empty so unreset storage never leaks out.
    always_comb begin
        bus.data_out  = '0;
        bus.valid_out = '0;
        bus.level     = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            bus.valid_out[i]              = (level_q[i] != '0);
            bus.level[i*LVL_W +: LVL_W]   = level_q[i];
            if (level_q[i] != '0) begin
                bus.data_out[i*DATA_W +: DATA_W] = mem_q[i][rptr_q[i]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       drop;

    always_comb begin
        drop      = bus.valid_in && !ready;
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        bus.err_cnt = err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_demux_nch_fifo.sv
// Scoreboard bench for demux_nch_fifo (CH=4, DEPTH=4, DATA_W=8); accepted words are queued
// per channel and a negedge monitor compares every popped head word against the queue.
module tb_demux_nch_fifo;
    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int DEP = 4;
    localparam int LW  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    demux_nch_fifo_if #(.DATA_W(DW), .CH(NCH), .DEPTH(DEP)) bus();

    demux_nch_fifo #(.DATA_W(DW), .CH(NCH), .DEPTH(DEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [NCH][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lvl(input int ch);
        return 32'(bus.level[ch*LW +: LW]);
    endfunction

    function automatic logic [31:0] head(input int ch);
        return 32'(bus.data_out[ch*DW +: DW]);
    endfunction

    // Inputs are held from posedge+1 to the next posedge; returns just after that edge.
    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] p, input bit expect_acc);
        bus.valid_in = v;
        bus.sel      = s;
        bus.data_in  = d;
        bus.pop      = p;
        if (v && expect_acc) exp_q[s].push_back(d);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.pop      = '0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.pop[i] && bus.valid_out[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow_ch%0d actual=0x%0h required=no_word", i,
                                 bus.data_out[i*DW +: DW]);
                    end else begin
                        check($sformatf("sb_data_ch%0d", i), 32'(bus.data_out[i*DW +: DW]),
                              32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        bus.valid_in = 1'b0;
        bus.sel      = '0;
        bus.data_in  = '0;
        bus.pop      = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // Reset / idle
        check("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_level", 32'(bus.level), 32'h0);
`ifdef DEMUX_ERR_CNT_EN
        check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
`endif
        for (int s = 0; s < NCH; s++) begin
            bus.sel = 2'(s);
            #1;
            check($sformatf("rst_ready_sel%0d", s), 32'(bus.ready_in), 32'h1);
        end
        @(posedge clk);
        #1;

        // Three pushes to ch2
        drive(1'b1, 2'd2, 8'h11, 4'b0000, 1'b1);
        check("push1_valid_out", 32'(bus.valid_out), 32'h4);
        check("push1_head2", head(2), 32'h11);
        drive(1'b1, 2'd2, 8'h22, 4'b0000, 1'b1);
        drive(1'b1, 2'd2, 8'h33, 4'b0000, 1'b1);
        check("push3_level2", lvl(2), 32'h3);
        check("push3_head2", head(2), 32'h11);

        // Fill ch1, then drop on full
        for (int k = 0; k < 4; k++) drive(1'b1, 2'd1, 8'hA0 + 8'(k), 4'b0000, 1'b1);
        check("full_level1", lvl(1), 32'h4);
        bus.sel = 2'd1;
        #1;
        check("full_ready_sel1", 32'(bus.ready_in), 32'h0);
        bus.sel = 2'd2;
        #1;
        check("lvl3_ready_sel2", 32'(bus.ready_in), 32'h1);
        drive(1'b1, 2'd1, 8'hFF, 4'b0000, 1'b0);
        check("drop_level1", lvl(1), 32'h4);
        check("drop_head1", head(1), 32'hA0);
`ifdef DEMUX_ERR_CNT_EN
        check("drop_err_cnt", 32'(bus.err_cnt), 32'h1);
`endif
        // Drain ch1 and ch2 together
        repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b0110, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0);
        check("drain_valid_out", 32'(bus.valid_out), 32'h0);
        check("drain_level1", lvl(1), 32'h0);

        // Simultaneous push and pop at level 2
        drive(1'b1, 2'd0, 8'h41, 4'b0000, 1'b1);
        drive(1'b1, 2'd0, 8'h42, 4'b0000, 1'b1);
        check("pp_level0_before", lvl(0), 32'h2);
        drive(1'b1, 2'd0, 8'h55, 4'b0001, 1'b1);
        check("pp_level0_after", lvl(0), 32'h2);
        check("pp_head0", head(0), 32'h42);
        repeat (2) drive(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
        check("pp_drained_valid0", 32'(bus.valid_out[0]), 32'h0);

        // Pop on empty channel is ignored
        drive(1'b0, 2'd0, 8'h00, 4'b1000, 1'b0);
        check("empty_pop_level3", lvl(3), 32'h0);
        check("empty_head3", head(3), 32'h0);

        // Pointer wrap on ch0 (pointers start at 3)
        drive(1'b1, 2'd0, 8'h60, 4'b0000, 1'b1);
        for (int k = 1; k < 6; k++) drive(1'b1, 2'd0, 8'h60 + 8'(k), 4'b0001, 1'b1);
        drive(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
        check("wrap_valid_out", 32'(bus.valid_out), 32'h0);
        total = 0;
        for (int i = 0; i < NCH; i++) total += exp_q[i].size();
        check("sb_drained", 32'(total), 32'h0);

        // Repeated drops on full ch0: counter saturates, FIFO untouched
        for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 8'h70 + 8'(k), 4'b0000, 1'b1);
        repeat (260) drive(1'b1, 2'd0, 8'hEE, 4'b0000, 1'b0);
        check("sat_level0", lvl(0), 32'h4);
        check("sat_head0", head(0), 32'h70);
`ifdef DEMUX_ERR_CNT_EN
        check("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);
`endif

        // Asynchronous reset with ch3 at level 3
        for (int k = 1; k < 4; k++) drive(1'b1, 2'd3, 8'h30 + 8'(k), 4'b0000, 1'b1);
        check("pre_rst_level3", lvl(3), 32'h3);
        check("pre_rst_valid_out", 32'(bus.valid_out), 32'h9);
        #2 reset = 1'b1;
        #1;
        check("arst_valid3", 32'(bus.valid_out[3]), 32'h0);
        check("arst_level3", lvl(3), 32'h0);
        check("arst_valid_out", 32'(bus.valid_out), 32'h0);
        check("arst_data_out", bus.data_out, 32'h0);
`ifdef DEMUX_ERR_CNT_EN
        check("arst_err_cnt", 32'(bus.err_cnt), 32'h0);
`endif
        for (int i = 0; i < NCH; i++) exp_q[i].delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 8'h99, 4'b0000, 1'b1);
        check("post_rst_level3", lvl(3), 32'h1);
        check("post_rst_head3", head(3), 32'h99);
        drive(1'b0, 2'd0, 8'h00, 4'b1000, 1'b0);
        check("post_rst_valid_out", 32'(bus.valid_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
